// File: rtl/mailbox_pkg.sv
// Shared definitions for both ends of the 4-slot BRAM mailbox.
// The producer (port A) and the reader (port B) import the same slot layout.
package mailbox_pkg;

  localparam int SLOT_W      = 9;
  localparam int FULL_BIT    = 8;
  localparam int MBOX_ADDR_W = 2;
  localparam logic [SLOT_W-1:0] CLEAR_WORD = 9'h000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_CLEAR,
    ST_OUT,
    ST_BACKOFF
  } mbox_rd_state_t;

  function automatic logic slot_is_full(input logic [SLOT_W-1:0] word);
    return word[FULL_BIT];
  endfunction

endpackage

// File: rtl/bram_mailbox_reader.sv
// Consumer end of the BRAM mailbox: polls slots in order on port B, pops and
// clears each full slot, and hands the byte out on a valid/ready stream.
module bram_mailbox_reader
  import mailbox_pkg::*;
#(
  parameter int BRAM_LAT = 2,
  parameter int POLL_GAP = 8
) (
  input  logic                   clk_100mhz,
  input  logic                   rst_n,
  input  logic                   en,
  output logic [MBOX_ADDR_W-1:0] bram_addrb,
  output logic [SLOT_W-1:0]      bram_dinb,
  output logic                   bram_web,
  input  logic [SLOT_W-1:0]      bram_doutb,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic [15:0]            bytes_popped
);

  localparam logic [7:0] WAIT_LOAD = 8'(BRAM_LAT - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(POLL_GAP - 1);

  mbox_rd_state_t         state_q;
  mbox_rd_state_t         resume_d;
  logic [MBOX_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]             cnt_q;
  logic [7:0]             byte_q;
  logic                   valid_q;
  logic                   web_q;
  logic [15:0]            popped_q, popped_d;

  // Both pointer and counter wrap naturally at their widths.
  assign rd_ptr_d = rd_ptr_q + 1'b1;
  assign popped_d = popped_q + 16'd1;
  assign resume_d = en ? ST_ISSUE : ST_IDLE;

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      web_q    <= 1'b0;
      popped_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          cnt_q   <= WAIT_LOAD;
          state_q <= (BRAM_LAT == 1) ? ST_CHECK : ST_WAIT;
        end
        ST_WAIT: begin
          // Counter reaches 0 on this cycle's decrement: data is valid next cycle.
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q <= 8'd1) state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (slot_is_full(bram_doutb)) begin
            byte_q  <= bram_doutb[FULL_BIT-1:0];
            web_q   <= 1'b1;
            state_q <= ST_CLEAR;
          end else begin
            cnt_q   <= GAP_LOAD;
            state_q <= ST_BACKOFF;
          end
        end
        ST_CLEAR: begin
          web_q   <= 1'b0;
          valid_q <= 1'b1;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          // The slot is already cleared, so the byte must leave even if en fell.
          if (byte_ready) begin
            valid_q  <= 1'b0;
            rd_ptr_q <= rd_ptr_d;
            popped_q <= popped_d;
            state_q  <= resume_d;
          end
        end
        ST_BACKOFF: begin
          if (cnt_q == 8'd0) state_q <= resume_d;
          else               cnt_q   <= cnt_q - 8'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bram_addrb   = rd_ptr_q;
  assign bram_dinb    = CLEAR_WORD;
  assign bram_web     = web_q;
  assign byte_out     = byte_q;
  assign byte_valid   = valid_q;
  assign bytes_popped = popped_q;

endmodule

// File: tb/tb_bram_mailbox_reader.sv
// Bench for bram_mailbox_reader: BRAM + producer model, an in-order byte
// scoreboard checked every cycle, and directed scenarios with literal checks.
module tb_bram_mailbox_reader;

  logic       clk_100mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] bram_addrb;
  logic [8:0] bram_dinb;
  logic       bram_web;
  logic [8:0] bram_doutb;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready = 1'b0;
  logic [15:0] bytes_popped;

  logic       prod_we = 1'b0;
  logic [1:0] prod_addr = '0;
  logic [7:0] prod_data = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  bram_mailbox_reader #(.BRAM_LAT(2), .POLL_GAP(8)) dut (
    .clk_100mhz  (clk_100mhz),
    .rst_n       (rst_n),
    .en          (en),
    .bram_addrb  (bram_addrb),
    .bram_dinb   (bram_dinb),
    .bram_web    (bram_web),
    .bram_doutb  (bram_doutb),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .bytes_popped(bytes_popped)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Dual-port BRAM, port-B read latency 2; the producer writes on port A and
  // records every byte it deposits, which is the order the reader must emit.
  logic [8:0] mem [4];
  logic [8:0] rd_s1, rd_s2;
  logic [7:0] exp_q [64];
  int         wr_idx;

  always @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      rd_s1  <= '0;
      rd_s2  <= '0;
      wr_idx <= 0;
    end else begin
      rd_s1 <= mem[bram_addrb];
      rd_s2 <= rd_s1;
      if (bram_web) mem[bram_addrb] <= bram_dinb;
      if (prod_we) begin
        mem[prod_addr]       <= {1'b1, prod_data};
        exp_q[wr_idx[5:0]]   <= prod_data;
        wr_idx               <= wr_idx + 1;
      end
    end
  end
  assign bram_doutb = rd_s2;

  // Scoreboard: pops come out in producer order, one clear per pop, pointer
  // equals pops mod 4, and an offered byte is held until taken.
  int         rd_idx = 0;
  logic [15:0] m_cnt = '0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_byte = '0;
  logic       prev_web = 1'b0;
  int         webs = 0;
  logic [7:0] log_b [64];
  int         log_n = 0;

  initial begin
    forever begin
      @(negedge clk_100mhz);
      #1;
      if (!rst_n) begin
        chk("rst_valid", {31'd0, byte_valid}, 32'd0);
        chk("rst_web", {31'd0, bram_web}, 32'd0);
        chk("rst_popped", {16'd0, bytes_popped}, 32'd0);
        chk("rst_addr", {30'd0, bram_addrb}, 32'd0);
        rd_idx = 0; m_cnt = '0; prev_hold = 1'b0; prev_web = 1'b0; webs = 0;
      end else begin
        chk("popped_model", {16'd0, bytes_popped}, {16'd0, m_cnt});
        chk("addr_model", {30'd0, bram_addrb}, {30'd0, m_cnt[1:0]});
        if (prev_hold) begin
          chk("hold_valid", {31'd0, byte_valid}, 32'd1);
          chk("hold_byte", {24'd0, byte_out}, {24'd0, prev_byte});
        end
        if (bram_web) begin
          chk("clear_word", {23'd0, bram_dinb}, 32'd0);
          chk("clear_single", {31'd0, prev_web}, 32'd0);
          chk("clear_slot_full", {31'd0, mem[bram_addrb][8]}, 32'd1);
          chk("clear_no_valid", {31'd0, byte_valid}, 32'd0);
          webs++;
        end
        prev_web = bram_web;
        if (byte_valid && byte_ready) begin
          chk("pop_byte", {24'd0, byte_out},
              (rd_idx < wr_idx) ? {24'd0, exp_q[rd_idx[5:0]]} : 32'h100);
          chk("clears_per_pop", webs, 32'd1);
          log_b[log_n[5:0]] = byte_out;
          log_n++;
          rd_idx++;
          m_cnt++;
          webs = 0;
        end
        prev_hold = byte_valid && !byte_ready;
        prev_byte = byte_out;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; byte_ready = 1'b0; prod_we = 1'b0;
    repeat (2) @(negedge clk_100mhz);
    rst_n = 1'b1;
    @(negedge clk_100mhz);
  endtask

  // Commits on the posedge between two negedges.
  task automatic prod_write(input logic [1:0] a, input logic [7:0] d);
    prod_addr = a; prod_data = d; prod_we = 1'b1;
    @(negedge clk_100mhz);
    prod_we = 1'b0;
  endtask

  task automatic wait_popped(input logic [15:0] target, input int budget);
    int n = 0;
    while (bytes_popped != target && n < budget) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("wait_popped", {16'd0, bytes_popped}, {16'd0, target});
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!byte_valid && n < budget) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("wait_valid", {31'd0, byte_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    // Reset state
    #3;
    chk("t0_valid", {31'd0, byte_valid}, 32'd0);
    chk("t0_byte", {24'd0, byte_out}, 32'd0);
    chk("t0_dinb", {23'd0, bram_dinb}, 32'd0);
    do_reset();

    // Single pop of 9'h1AA from slot 0, latency from ISSUE
    prod_write(2'd0, 8'hAA);
    byte_ready = 1'b1; en = 1'b1;
    @(posedge clk_100mhz);
    repeat (2) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    chk("t1_web_early", {31'd0, bram_web}, 32'd0);
    @(negedge clk_100mhz);
    chk("t1_web", {31'd0, bram_web}, 32'd1);
    chk("t1_web_addr", {30'd0, bram_addrb}, 32'd0);
    chk("t1_valid_early", {31'd0, byte_valid}, 32'd0);
    @(negedge clk_100mhz);
    chk("t1_valid", {31'd0, byte_valid}, 32'd1);
    chk("t1_byte", {24'd0, byte_out}, 32'hAA);
    @(negedge clk_100mhz);
    chk("t1_popped", {16'd0, bytes_popped}, 32'd1);
    chk("t1_next_addr", {30'd0, bram_addrb}, 32'd1);
    chk("t1_valid_drop", {31'd0, byte_valid}, 32'd0);

    // Empty slots: polls read slot 0 at ISSUE+1 every 11 cycles, so a write
    // landing on the third poll's read edge is only seen by the fourth.
    do_reset();
    byte_ready = 1'b1; en = 1'b1;
    @(posedge clk_100mhz);
    repeat (22) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    chk("t2_idle_valid", {31'd0, byte_valid}, 32'd0);
    chk("t2_idle_addr", {30'd0, bram_addrb}, 32'd0);
    prod_write(2'd0, 8'h5A);
    repeat (12) @(negedge clk_100mhz);
    chk("t2_web_not_yet", {31'd0, bram_web}, 32'd0);
    @(negedge clk_100mhz);
    chk("t2_web_poll4", {31'd0, bram_web}, 32'd1);
    wait_popped(16'd1, 10);

    // Four slots then a refill of slot 0: in-order with pointer wrap
    do_reset();
    base = log_n;
    for (int i = 0; i < 4; i++) prod_write(2'(i), 8'(i + 1));
    byte_ready = 1'b1; en = 1'b1;
    wait_popped(16'd4, 80);
    chk("t3_wrap_addr", {30'd0, bram_addrb}, 32'd0);
    prod_write(2'd0, 8'h05);
    wait_popped(16'd5, 40);
    chk("t3_addr_after", {30'd0, bram_addrb}, 32'd1);
    for (int i = 0; i < 5; i++) chk("t3_order", {24'd0, log_b[(base + i) & 63]}, 32'(i + 1));

    // Backpressure: byte held for 20 cycles, pointer moves only on handshake
    do_reset();
    prod_write(2'd0, 8'h5C);
    en = 1'b1;
    wait_valid(20);
    repeat (20) begin
      @(negedge clk_100mhz);
      chk("t4_hold_valid", {31'd0, byte_valid}, 32'd1);
      chk("t4_hold_byte", {24'd0, byte_out}, 32'h5C);
      chk("t4_hold_addr", {30'd0, bram_addrb}, 32'd0);
    end
    byte_ready = 1'b1;
    @(negedge clk_100mhz);
    chk("t4_popped", {16'd0, bytes_popped}, 32'd1);
    chk("t4_addr", {30'd0, bram_addrb}, 32'd1);

    // en drops during WAIT: pop completes, then no further polls
    do_reset();
    prod_write(2'd0, 8'h77);
    prod_write(2'd1, 8'h88);
    byte_ready = 1'b1; en = 1'b1;
    @(posedge clk_100mhz);
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    en = 1'b0;
    repeat (40) @(negedge clk_100mhz);
    chk("t5_popped", {16'd0, bytes_popped}, 32'd1);
    chk("t5_byte", {24'd0, log_b[(log_n - 1) & 63]}, 32'h77);
    chk("t5_addr", {30'd0, bram_addrb}, 32'd1);
    chk("t5_slot0_clear", {23'd0, mem[0]}, 32'd0);
    chk("t5_slot1_kept", {23'd0, mem[1]}, 32'h188);

    // Reset during OUT: immediate return to reset values, resume at slot 0
    do_reset();
    prod_write(2'd0, 8'h3C);
    en = 1'b1;
    wait_valid(20);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, byte_valid}, 32'd0);
    chk("t6_byte", {24'd0, byte_out}, 32'd0);
    chk("t6_addr", {30'd0, bram_addrb}, 32'd0);
    @(negedge clk_100mhz);
    @(negedge clk_100mhz);
    rst_n = 1'b1;
    prod_write(2'd0, 8'h4D);
    byte_ready = 1'b1;
    wait_popped(16'd1, 30);
    chk("t6_byte_after", {24'd0, log_b[(log_n - 1) & 63]}, 32'h4D);
    chk("t6_addr_after", {30'd0, bram_addrb}, 32'd1);

    @(negedge clk_100mhz);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
